ram_sp_hs: RTL and testbench
============================

Name: ram_sp_hs

Overview:
- Parametrised single-port synchronous RAM with a valid/ready request interface, per-byte write strobes and a selectable read latency of 1 or 2.
- Includes a hardware clear sequencer that zero-fills the array after reset or on command.
- Out-of-range accesses are flagged.
- Next-generation instruction/data store for the MiniMicro core. It replaces hard-coded memory contents and the overloaded read/write select.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width.
- RD_LAT, 1, read latency in cycles from acceptance to rsp_valid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after every reset; 0 = leave contents undefined and go straight to READY.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  RAM can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte write enables; bit i covers bits [8i+7:8i].
- clear_start  input  1  one-cycle pulse that starts a runtime clear; honoured only in READY.
- rsp_valid  output  1  one-cycle pulse; rsp_rdata is valid this cycle.
- rsp_rdata  output  DATA_W  read data.
- rsp_err  output  1  qualifies rsp_valid; 1 = the read address was >= DEPTH.
- wr_err  output  1  one-cycle pulse when a write to an address >= DEPTH is accepted.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0.
  - busy=CLEAR_ON_RESET.
  - Clear counter = 0; read pipeline empty.
  - Memory array contents are not reset directly.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR: writes 0 to address cnt each cycle, cnt runs 0..DEPTH-1. It takes exactly DEPTH cycles. busy=1 and req_ready=0. After the write to DEPTH-1 it moves to READY, and busy deasserts in that same transition.
  - READY: req_ready=1, busy=0.
  - clear_start=1 in READY moves to CLEAR next cycle with cnt=0. If req_valid is high in that same cycle, that request is still accepted (req_ready is 1) and completes normally.
  - clear_start is ignored while in CLEAR.
- Acceptance: a request is accepted when req_valid && req_ready. At most one request is accepted per cycle. req_valid high while req_ready is low is simply stalled; the requester holds it.
- Writes:
  - mem[addr] byte i is updated at the accepting edge iff req_be[i].
  - req_be = 0 is a legal no-op.
  - A write produces no rsp_valid.
- Reads:
  - The array is sampled at the accepting edge.
  - RD_LAT=1: rsp_valid/rsp_rdata are registered one cycle after acceptance.
  - RD_LAT=2: one extra output register stage is added.
  - There is no response backpressure. Back-to-back reads give back-to-back rsp_valid pulses in order.
- Read-after-write:
  - A read accepted in the cycle after a write to the same address returns the new, byte-merged data.
  - Write-then-read ordering is exact because a single port accepts one request per cycle.
- Out of range (addr >= DEPTH):
  - A write is ignored (the array is untouched) and wr_err pulses in the cycle after acceptance.
  - A read returns rsp_rdata=0 with rsp_err=1 at normal latency.
- Reads in flight when a clear starts complete with the data sampled at acceptance, not zero.
- rsp_rdata holds its last value when rsp_valid=0.
- Asynchronous reset mid-operation:
  - The pipeline is flushed: no stale rsp_valid appears after reset release.
  - Any in-progress clear restarts from cnt=0.
  - A write at the reset edge is not guaranteed.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=32 -> busy=1 and req_ready=0 for exactly 32 cycles, then ready; reads of addr 0, 17 and 31 return 0x00000000.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x000000AA with be=4'b0001 -> read of addr 5 returns 0xDEADBEAA.
- RD_LAT=1 and RD_LAT=2: four back-to-back reads of addr 0..3, preloaded with 0x10..0x13 -> rsp_valid high for 4 consecutive cycles starting 1 (resp. 2) cycles after the first acceptance, data 0x10,0x11,0x12,0x13 in order.
- DEPTH=20: write to addr 25 -> wr_err pulse and no array change; read of addr 25 -> rsp_valid with rsp_err=1 and rsp_rdata=0.
- Fill addr 3 with 0x55; issue clear_start together with a read of addr 3 -> the read response returns 0x55, busy is high for 20 cycles, and a later read of addr 3 returns 0.
- Assert rst_n=0 for 1 cycle mid-clear and during an outstanding read -> no rsp_valid after release, and the clear restarts and takes the full DEPTH cycles.

Source files
------------

// File: rtl/ram_sp_hs.sv
// Single-port synchronous RAM: valid/ready requests, byte write strobes,
// 1- or 2-cycle registered read latency and a zero-fill clear sequencer.
module ram_sp_hs #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = $clog2(DEPTH),
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic                clear_start,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                wr_err,
  output logic                busy
);

  localparam int unsigned       BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_e;
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                clr_we_c;
  logic                accept_c, in_range_c, rd_acc_c, wr_acc_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign accept_c   = req_valid && ready_q;
  assign in_range_c = {1'b0, req_addr} < DEPTH_X;
  assign rd_acc_c   = accept_c && !req_we;
  assign wr_acc_c   = accept_c && req_we;
  assign rd_data_c  = in_range_c ? mem_q[req_addr] : '0;

  // Clear sequencer: one zero write per cycle, then back to READY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we_c = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_READY: begin
        if (clear_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = RST_STATE;
    endcase
    ready_d = (state_d == S_READY);
    busy_d  = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;

  // Array has no reset; out-of-range writes never touch it.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc_c && in_range_c) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem_q[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  logic              v1_q, e1_q, wr_err_q;
  logic [DATA_W-1:0] d1_q;

  // First read stage; data/err hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      d1_q     <= '0;
      e1_q     <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      v1_q     <= rd_acc_c;
      wr_err_q <= wr_acc_c && !in_range_c;
      if (rd_acc_c) begin
        d1_q <= rd_data_c;
        e1_q <= !in_range_c;
      end
    end
  end

  assign wr_err = wr_err_q;

  if (RD_LAT >= 2) begin : g_lat2
    logic              v2_q, e2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
        e2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q <= d1_q;
          e2_q <= e1_q;
        end
      end
    end

    assign rsp_valid = v2_q;
    assign rsp_rdata = d2_q;
    assign rsp_err   = e2_q;
  end else begin : g_lat1
    assign rsp_valid = v1_q;
    assign rsp_rdata = d1_q;
    assign rsp_err   = e1_q;
  end

endmodule

// File: tb/tb_ram_sp_hs.sv
// Scoreboard bench for ram_sp_hs: two instances (DEPTH=32/RD_LAT=1 and
// DEPTH=20/RD_LAT=2) driven by the same request stream.
module tb_ram_sp_hs;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int DEPTH_A = 32;
  localparam int DEPTH_B = 20;
  localparam int LAT_A   = 1;
  localparam int LAT_B   = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            due;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, clear_start;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rdy_a, rv_a, re_a, we_a, busy_a;
  logic          rdy_b, rv_b, re_b, we_b, busy_b;
  logic [DW-1:0] rd_a, rd_b;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  rsp_t          qa[$], qb[$];
  int            wqa[$], wqb[$];
  logic [DW-1:0] mdl_a [DEPTH_A];
  logic [DW-1:0] mdl_b [DEPTH_B];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  ram_sp_hs #(.DATA_W(DW), .DEPTH(DEPTH_A), .RD_LAT(LAT_A), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .clear_start(clear_start),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(re_a), .wr_err(we_a), .busy(busy_a));

  ram_sp_hs #(.DATA_W(DW), .DEPTH(DEPTH_B), .RD_LAT(LAT_B), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .clear_start(clear_start),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(re_b), .wr_err(we_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Response / write-error monitors for instance A.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_a = '0;
    end else begin
      if (qa.size() != 0 && qa[0].due <= cyc) begin
        chk("a_rsp_valid", 64'(rv_a), 64'd1);
        if (rv_a) begin
          chk("a_rsp_rdata", 64'(rd_a), 64'(qa[0].d));
          chk("a_rsp_err", 64'(re_a), 64'(qa[0].e));
        end
        void'(qa.pop_front());
      end else begin
        chk("a_rsp_valid_idle", 64'(rv_a), 64'd0);
      end
      if (!rv_a) chk("a_rdata_hold", 64'(rd_a), 64'(last_a));
      else last_a = rd_a;
      if (wqa.size() != 0 && wqa[0] <= cyc) begin
        chk("a_wr_err", 64'(we_a), 64'd1);
        void'(wqa.pop_front());
      end else begin
        chk("a_wr_err_idle", 64'(we_a), 64'd0);
      end
    end
  end

  // Response / write-error monitors for instance B.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_b = '0;
    end else begin
      if (qb.size() != 0 && qb[0].due <= cyc) begin
        chk("b_rsp_valid", 64'(rv_b), 64'd1);
        if (rv_b) begin
          chk("b_rsp_rdata", 64'(rd_b), 64'(qb[0].d));
          chk("b_rsp_err", 64'(re_b), 64'(qb[0].e));
        end
        void'(qb.pop_front());
      end else begin
        chk("b_rsp_valid_idle", 64'(rv_b), 64'd0);
      end
      if (!rv_b) chk("b_rdata_hold", 64'(rd_b), 64'(last_b));
      else last_b = rd_b;
      if (wqb.size() != 0 && wqb[0] <= cyc) begin
        chk("b_wr_err", 64'(we_b), 64'd1);
        void'(wqb.pop_front());
      end else begin
        chk("b_wr_err_idle", 64'(we_b), 64'd0);
      end
    end
  end

  function automatic void zero_models();
    for (int i = 0; i < DEPTH_A; i++) mdl_a[i] = '0;
    for (int i = 0; i < DEPTH_B; i++) mdl_b[i] = '0;
  endfunction

  // Entered and left just after a rising edge; one request per call.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] be, input logic clr);
    int n = 0;
    while (!(rdy_a && rdy_b) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 64'(rdy_a && rdy_b), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wd; req_be = be; clear_start = clr;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mdl_a[int'(addr)][8*i +: 8] = wd[8*i +: 8];
          if (int'(addr) < DEPTH_B) mdl_b[int'(addr)][8*i +: 8] = wd[8*i +: 8];
        end
      end
      if (int'(addr) >= DEPTH_B) wqb.push_back(cyc + 1);
    end else begin
      qa.push_back('{d: mdl_a[int'(addr)], e: 1'b0, due: cyc + LAT_A});
      if (int'(addr) < DEPTH_B) qb.push_back('{d: mdl_b[int'(addr)], e: 1'b0, due: cyc + LAT_B});
      else qb.push_back('{d: '0, e: 1'b1, due: cyc + LAT_B});
    end
    if (clr) zero_models();
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; clear_start = 1'b0; req_be = '0;
  endtask

  // Counts busy cycles of each instance over a fixed window starting now.
  task automatic measure_clear(input string tag);
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a) na++;
      if (busy_b) nb++;
      chk({tag, "_a_ready_vs_busy"}, 64'(rdy_a), 64'(!busy_a));
      chk({tag, "_b_ready_vs_busy"}, 64'(rdy_b), 64'(!busy_b));
    end
    chk({tag, "_a_busy_cycles"}, 64'(na), 64'(DEPTH_A));
    chk({tag, "_b_busy_cycles"}, 64'(nb), 64'(DEPTH_B));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    qa.delete(); qb.delete(); wqa.delete(); wqb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    zero_models();
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; clear_start = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    zero_models();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_a_ready", 64'(rdy_a), 64'd0);
    chk("rst_a_rsp_valid", 64'(rv_a), 64'd0);
    chk("rst_a_rdata", 64'(rd_a), 64'd0);
    chk("rst_a_rsp_err", 64'(re_a), 64'd0);
    chk("rst_a_wr_err", 64'(we_a), 64'd0);
    chk("rst_a_busy", 64'(busy_a), 64'd1);
    chk("rst_b_ready", 64'(rdy_b), 64'd0);
    chk("rst_b_rsp_valid", 64'(rv_b), 64'd0);
    chk("rst_b_busy", 64'(busy_b), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    measure_clear("por");

    do_req(1'b0, 5'd0, '0, 4'h0, 1'b0);
    do_req(1'b0, 5'd17, '0, 4'h0, 1'b0);
    do_req(1'b0, 5'd31, '0, 4'h0, 1'b0);

    do_req(1'b1, 5'd5, 32'hDEADBEEF, 4'b1111, 1'b0);
    do_req(1'b1, 5'd5, 32'h000000AA, 4'b0001, 1'b0);
    do_req(1'b0, 5'd5, '0, 4'h0, 1'b0);
    do_req(1'b1, 5'd5, 32'hFFFFFFFF, 4'b0000, 1'b0);
    do_req(1'b0, 5'd5, '0, 4'h0, 1'b0);

    for (int i = 0; i < 4; i++) do_req(1'b1, AW'(i), DW'(32'h10 + i), 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) do_req(1'b0, AW'(i), '0, 4'h0, 1'b0);

    do_req(1'b1, 5'd25, 32'h12345678, 4'hF, 1'b0);
    do_req(1'b0, 5'd25, '0, 4'h0, 1'b0);
    do_req(1'b0, 5'd19, '0, 4'h0, 1'b0);
    do_req(1'b1, 5'd20, 32'hCAFEF00D, 4'b0110, 1'b0);
    do_req(1'b0, 5'd20, '0, 4'h0, 1'b0);

    do_req(1'b1, 5'd3, 32'h00000055, 4'hF, 1'b0);
    do_req(1'b0, 5'd3, '0, 4'h0, 1'b1);
    measure_clear("rtclr");
    do_req(1'b0, 5'd3, '0, 4'h0, 1'b0);
    do_req(1'b0, 5'd5, '0, 4'h0, 1'b0);

    do_req(1'b1, 5'd7, 32'h77777777, 4'hF, 1'b0);
    do_req(1'b1, 5'd9, 32'h99999999, 4'hF, 1'b0);
    do_req(1'b0, 5'd7, '0, 4'h0, 1'b1);
    pulse_reset();
    measure_clear("rst_rd");

    do_req(1'b1, 5'd9, 32'h99999999, 4'hF, 1'b0);
    do_req(1'b1, 5'd0, '0, 4'h0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    pulse_reset();
    measure_clear("rst_mid");
    do_req(1'b0, 5'd9, '0, 4'h0, 1'b0);
    do_req(1'b0, 5'd0, '0, 4'h0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("a_rsp_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_rsp_queue_drained", 64'(qb.size()), 64'd0);
    chk("b_wr_err_queue_drained", 64'(wqb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
